// File: rtl/alu_pkg.sv
// Shared ALU package: SELECT opcode codes, divider state encoding and
// small decode helpers used by the EX-stage divide unit.
package alu_pkg;

  // Existing single-cycle ALU operation codes
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_MUL    = 5'b01010;
  localparam logic [4:0] ALU_MULH   = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b10000;
  localparam logic [4:0] ALU_MULHU  = 5'b10001;

  // RV32M divide / remainder codes handled by the multi-cycle unit
  localparam logic [4:0] ALU_DIV  = 5'b01100;
  localparam logic [4:0] ALU_DIVU = 5'b01101;
  localparam logic [4:0] ALU_REM  = 5'b01110;
  localparam logic [4:0] ALU_REMU = 5'b01111;

  // Divider FSM state encoding
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIN  = 2'd2;

  // Signed flavours; anything unrecognised behaves like DIVU
  function automatic logic sel_is_signed(input logic [4:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

  // Remainder flavours select the remainder instead of the quotient
  function automatic logic sel_is_rem(input logic [4:0] sel);
    return (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_restoring_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
// The trial subtraction is WIDTH+1 bits wide so its sign bit directly
// tells whether the shifted partial remainder could absorb the divisor.
module div_restoring_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try the subtraction
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
  end

  // Load operands, then accept one restoring step per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last      = (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Wraps div_restoring_core with the IDLE/CALC/FIN control, sign handling,
// RISC-V special cases and the RESULT register.
// Optional feature macro: ALU_DIV_EARLY_OUT_EN -- divide-by-zero, signed
// overflow and |DATA1| < |DATA2| skip CALC and finish in two cycles.
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             FLUSH,
  input  logic [4:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]       state;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             is_signed;
  logic             is_rem;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;
  logic             ovf;
  logic             accept;
  logic             skip_calc;

  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;
  logic             ovf_q;
  logic             skip_q;
  logic [WIDTH-1:0] data1_q;

  logic             core_last;
  logic [WIDTH-1:0] core_quo;
  logic [WIDTH-1:0] core_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] fin_value;

  // Decode the request and form operand magnitudes and special-case flags
  always_comb begin
    is_signed = sel_is_signed(SELECT);
    is_rem    = sel_is_rem(SELECT);
    neg_a     = is_signed & DATA1[WIDTH-1];
    neg_b     = is_signed & DATA2[WIDTH-1];
    abs_a     = neg_a ? (~DATA1 + 1'b1) : DATA1;
    abs_b     = neg_b ? (~DATA2 + 1'b1) : DATA2;
    div_zero  = (DATA2 == '0);
    ovf       = is_signed && (DATA1 == MIN_VAL) && (DATA2 == ALL_ONES);
    accept    = (state == DIV_IDLE) && START && !FLUSH;
  end

`ifdef ALU_DIV_EARLY_OUT_EN
  assign skip_calc = div_zero | ovf | (abs_a < abs_b);
`else
  assign skip_calc = 1'b0;
`endif

  div_restoring_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (accept),
    .step      (state == DIV_CALC),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .last      (core_last),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Restore signs on the unsigned result and override the mandated special cases
  always_comb begin
    quo_fix = neg_quo_q ? (~core_quo + 1'b1) : core_quo;
    rem_fix = neg_rem_q ? (~core_rem + 1'b1) : core_rem;
    if (div_zero_q) begin
      quo_fix = ALL_ONES;
      rem_fix = data1_q;
    end else if (ovf_q) begin
      quo_fix = MIN_VAL;
      rem_fix = '0;
    end else if (skip_q) begin
      quo_fix = '0;
      rem_fix = data1_q;
    end
    fin_value = is_rem_q ? rem_fix : quo_fix;
  end

  // Control FSM: accept in IDLE, iterate in CALC, publish RESULT from FIN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= DIV_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      skip_q     <= 1'b0;
      data1_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            is_rem_q   <= is_rem;
            neg_quo_q  <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
            div_zero_q <= div_zero;
            ovf_q      <= ovf;
            skip_q     <= skip_calc;
            data1_q    <= DATA1;
            busy_q     <= 1'b1;
            state      <= skip_calc ? DIV_FIN : DIV_CALC;
          end
        end
        DIV_CALC: begin
          if (FLUSH) begin
            busy_q <= 1'b0;
            state  <= DIV_IDLE;
          end else if (core_last) begin
            state <= DIV_FIN;
          end
        end
        DIV_FIN: begin
          if (!FLUSH) begin
            result_q <= fin_value;
            done_q   <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= DIV_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= DIV_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// Self-checking bench for alu_div_unit (WIDTH=32): directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written FLUSH / RESET / ignored-START sequences.
// Build with or without ALU_DIV_EARLY_OUT_EN; expected latencies follow it.
module tb_alu_div_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [4:0]  sel;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_exp;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  alu_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .START  (start),
    .FLUSH  (flush),
    .SELECT (sel),
    .DATA1  (data1),
    .DATA2  (data2),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // RISC-V division semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (s == ALU_DIV) || (s == ALU_REM);
    bit want_rem = (s == ALU_REM) || (s == ALU_REMU);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return want_rem ? r : q;
  endfunction

  // Whether the operation takes the short path in this build
  function automatic bit ref_early(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_DIV_EARLY_OUT_EN
    bit sgn = (s == ALU_DIV) || (s == ALU_REM);
    longint sa, sb, ma, mb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return 1'b1;
    if (sgn && sa == -64'sd2147483648 && sb == -64'sd1) return 1'b1;
    ma = sgn ? ((sa < 0) ? -sa : sa) : longint'({32'd0, a});
    mb = sgn ? ((sb < 0) ? -sb : sb) : longint'({32'd0, b});
    return ma < mb;
`else
    return (s == 5'd31) && (a != a) && (b != b);
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for DONE
  task automatic apply_stimulus(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int edges, output int busy_cycles);
    sel = s;
    data1 = a;
    data2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    busy_cycles = busy ? 1 : 0;
    check_output("done_low_after_accept", {31'd0, done}, 32'd0);
    while (!done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cycles++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no DONE, expected DONE within 100 cycles");
    end
    res = result;
  endtask

  // Run one operation and compare result and timing against the model
  task automatic run_and_check(input string name, input logic [4:0] s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int edges, busy_cycles;
    bit early;
    early = ref_early(s, a, b);
    apply_stimulus(s, a, b, res, edges, busy_cycles);
    check_output({name, "_result"}, res, exp);
    check_output({name, "_done_edge"}, 32'(edges), early ? 32'd1 : 32'd33);
    check_output({name, "_busy_cycles"}, 32'(busy_cycles), early ? 32'd1 : 32'd33);
    last_exp = exp;
  endtask

  initial begin
    logic [4:0]  rs;
    logic [31:0] ra, rb;
    int          n;
    bit          seen_done;

    tbl[0]  = '{ALU_DIV,  32'd100,        32'd7,          32'd14};
    tbl[1]  = '{ALU_REM,  32'd100,        32'd7,          32'd2};
    tbl[2]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    tbl[3]  = '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    tbl[4]  = '{ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
    tbl[5]  = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    tbl[6]  = '{ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    tbl[7]  = '{ALU_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF};
    tbl[8]  = '{ALU_DIVU, 32'd3,          32'd5,          32'd0};
    tbl[9]  = '{ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
    tbl[10] = '{ALU_REM,  32'd5,          32'd0,          32'd5};
    tbl[11] = '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tbl[12] = '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    tbl[13] = '{ALU_ADD,  32'd100,        32'd7,          32'd14};
    tbl[14] = '{ALU_REMU, 32'd5,          32'd0,          32'd5};
    tbl[15] = '{ALU_REM,  32'hFFFF_FFF9,  32'd100,        32'hFFFF_FFF9};

    // Reset, with START held high to show reset dominates it
    rst_n = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    sel = ALU_DIV;
    data1 = 32'd100;
    data2 = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_result", result, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++)
      run_and_check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].exp);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 4);
      rs = (n < 4) ? 5'(ALU_DIV + 5'(n)) : 5'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : (ra >> $urandom_range(0, 31));
      endcase
      run_and_check($sformatf("rand%0d", i), rs, ra, rb, ref_model(rs, ra, rb));
    end

    $display("[TB] FLUSH in CALC cycle 10");
    run_and_check("pre_flush", ALU_DIV, 32'd100, 32'd7, 32'd14);
    sel = ALU_DIV;
    data1 = 32'd1000;
    data2 = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_output("flush_busy", {31'd0, busy}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check_output("flush_no_done", {31'd0, seen_done}, 32'd0);
    check_output("flush_result_kept", result, last_exp);
    run_and_check("post_flush", ALU_REM, 32'd1000, 32'd3, 32'd1);

    $display("[TB] START while BUSY is ignored");
    sel = ALU_DIVU;
    data1 = 32'd100;
    data2 = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
    end
    sel = ALU_REM;
    data1 = 32'hFFFF_FFF9;
    data2 = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    n++;
    start = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("busy_start_result", result, 32'd14);
    check_output("busy_start_done_edge", 32'(n), 32'd33);

    $display("[TB] FLUSH and START together in IDLE");
    @(posedge clk);
    #1;
    sel = ALU_DIV;
    data1 = 32'd100;
    data2 = 32'd7;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check_output("idle_flush_busy", {31'd0, busy}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check_output("idle_flush_no_done", {31'd0, seen_done}, 32'd0);
    check_output("idle_flush_result", result, 32'd14);

    $display("[TB] RESET mid-CALC");
    run_and_check("pre_reset", ALU_DIVU, 32'd1000, 32'd3, 32'd333);
    sel = ALU_DIVU;
    data1 = 32'd5000;
    data2 = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("midreset_busy", {31'd0, busy}, 32'd0);
    check_output("midreset_done", {31'd0, done}, 32'd0);
    check_output("midreset_result", result, 32'd0);
    run_and_check("post_reset", ALU_DIVU, 32'd5000, 32'd7, 32'd714);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
